// File: rtl/segre_fetch_queue_pkg.sv
// Shared types and constants for the IF/ID decoupling fetch queue.
package segre_fetch_queue_pkg;

    localparam int WORD_SIZE = 32;
    localparam int ADDR_SIZE = 32;

    // addi x0,x0,0 -- what ID sees whenever the queue is empty
    localparam logic [WORD_SIZE-1:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [WORD_SIZE-1:0] instr;
        logic [ADDR_SIZE-1:0] pc;
    } fq_entry_t;

endpackage

// File: rtl/segre_fetch_queue_if.sv
// IF-side enqueue, ID-side dequeue and flush signals of the fetch queue.
interface segre_fetch_queue_if
    import segre_fetch_queue_pkg::*;
#(
    parameter int DEPTH = 4
);
    logic                   valid_if_i;
    logic [WORD_SIZE-1:0]   instr_i;
    logic [ADDR_SIZE-1:0]   pc_i;
    logic                   ready_o;
    logic                   almost_full_o;
    logic                   flush_i;
    logic                   id_ready_i;
    logic                   valid_id_o;
    logic [WORD_SIZE-1:0]   instr_o;
    logic [ADDR_SIZE-1:0]   pc_o;
    logic [$clog2(DEPTH):0] count_o;

    modport master (
        output valid_if_i, instr_i, pc_i, flush_i, id_ready_i,
        input  ready_o, almost_full_o, valid_id_o, instr_o, pc_o, count_o
    );

    modport slave (
        input  valid_if_i, instr_i, pc_i, flush_i, id_ready_i,
        output ready_o, almost_full_o, valid_id_o, instr_o, pc_o, count_o
    );

endinterface

// File: rtl/segre_fetch_queue.sv
// Fetch queue between IF and ID: FIFO of {instr, pc}, flushed on taken branch,
// presents a NOP with valid low while empty.
module segre_fetch_queue
    import segre_fetch_queue_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    segre_fetch_queue_if.slave fq
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    fq_entry_t        mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;
    logic             ready;
    logic             valid;
    logic             enq;
    logic             deq;

    // ready comes from count alone, so id_ready_i never reaches it combinationally
    assign ready = (count < CNT_W'(DEPTH));
    assign valid = (count != '0);
    assign enq   = fq.valid_if_i && ready && !fq.flush_i;
    assign deq   = fq.id_ready_i && valid && !fq.flush_i;

    always_ff @(posedge clk_i) begin
        if (rst_i || fq.flush_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (enq) wr_ptr <= wr_ptr + PTR_W'(1);
            if (deq) rd_ptr <= rd_ptr + PTR_W'(1);
            case ({enq, deq})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // storage is deliberately not reset; the output mux masks it while empty
    always_ff @(posedge clk_i) begin
        if (!rst_i && enq) begin
            mem[wr_ptr] <= '{instr: fq.instr_i, pc: fq.pc_i};
        end
    end

    always_comb begin
        fq.instr_o = NOP_INSTR;
        fq.pc_o    = '0;
        if (valid) begin
            fq.instr_o = mem[rd_ptr].instr;
            fq.pc_o    = mem[rd_ptr].pc;
        end
    end

    assign fq.valid_id_o    = valid;
    assign fq.ready_o       = ready;
    assign fq.almost_full_o = (count >= CNT_W'(DEPTH - 1));
    assign fq.count_o       = count;

endmodule

// File: tb/tb_segre_fetch_queue.sv
// Scoreboard bench for segre_fetch_queue: a reference queue tracks expected contents.
module tb_segre_fetch_queue;
    import segre_fetch_queue_pkg::*;

    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;
    fq_entry_t sb[$];

    always #5 clk = ~clk;

    segre_fetch_queue_if #(.DEPTH(DEPTH)) bus ();

    segre_fetch_queue #(.DEPTH(DEPTH)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .fq    (bus)
    );

    function automatic logic [31:0] mk_instr(input logic [31:0] pc);
        return {pc[15:0], 16'h0533} ^ 32'h5A5A_0000;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_outputs(input string tag);
        logic [31:0] e_instr;
        logic [31:0] e_pc;
        e_instr = NOP_INSTR;
        e_pc    = '0;
        if (sb.size() != 0) begin
            e_instr = sb[0].instr;
            e_pc    = sb[0].pc;
        end
        chk({tag, ".valid"}, 32'(bus.valid_id_o),    32'(sb.size() != 0));
        chk({tag, ".count"}, 32'(bus.count_o),       32'(sb.size()));
        chk({tag, ".ready"}, 32'(bus.ready_o),       32'(sb.size() < DEPTH));
        chk({tag, ".afull"}, 32'(bus.almost_full_o), 32'(sb.size() >= DEPTH - 1));
        chk({tag, ".instr"}, bus.instr_o, e_instr);
        chk({tag, ".pc"},    bus.pc_o,    e_pc);
    endtask

    // check state from the previous edge, apply inputs, then advance the model at the edge
    task automatic cyc(input string tag, input logic r, input logic v,
                       input logic [31:0] pc, input logic idr, input logic fl);
        fq_entry_t e;
        logic do_enq;
        logic do_deq;
        @(negedge clk);
        check_outputs(tag);
        rst            = r;
        bus.valid_if_i = v;
        bus.pc_i       = pc;
        bus.instr_i    = mk_instr(pc);
        bus.id_ready_i = idr;
        bus.flush_i    = fl;
        @(posedge clk);
        if (r || fl) begin
            sb.delete();
        end else begin
            do_enq = v && (sb.size() < DEPTH);
            do_deq = idr && (sb.size() != 0);
            if (do_deq) void'(sb.pop_front());
            if (do_enq) begin
                e.instr = mk_instr(pc);
                e.pc    = pc;
                sb.push_back(e);
            end
        end
    endtask

    initial begin
        bus.valid_if_i = 1'b0;
        bus.instr_i    = '0;
        bus.pc_i       = '0;
        bus.id_ready_i = 1'b0;
        bus.flush_i    = 1'b0;
        rst            = 1'b1;
        repeat (2) @(posedge clk);
        sb.delete();

        // reset state, then fill past full with ID blocked
        cyc("rst",  1'b0, 1'b1, 32'h0,  1'b0, 1'b0);
        cyc("fill", 1'b0, 1'b1, 32'h4,  1'b0, 1'b0);
        cyc("fill", 1'b0, 1'b1, 32'h8,  1'b0, 1'b0);
        cyc("fill", 1'b0, 1'b1, 32'hC,  1'b0, 1'b0);
        cyc("full", 1'b0, 1'b1, 32'h10, 1'b0, 1'b0);
        cyc("full", 1'b0, 1'b1, 32'h14, 1'b1, 1'b0);

        // drain in order, then sit empty
        for (int i = 0; i < 4; i++) cyc("drain", 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        cyc("empty", 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);

        // count=2 then simultaneous enq+deq, wrapping the pointers
        cyc("pre2", 1'b0, 1'b1, 32'h100, 1'b0, 1'b0);
        cyc("pre2", 1'b0, 1'b1, 32'h104, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++)
            cyc("simul", 1'b0, 1'b1, 32'h108 + 32'(4 * i), 1'b1, 1'b0);
        cyc("simul", 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        cyc("simul", 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);

        // flush at count=3 together with enq and deq
        cyc("pre3", 1'b0, 1'b1, 32'h20, 1'b0, 1'b0);
        cyc("pre3", 1'b0, 1'b1, 32'h24, 1'b0, 1'b0);
        cyc("pre3", 1'b0, 1'b1, 32'h28, 1'b0, 1'b0);
        cyc("flush", 1'b0, 1'b1, 32'h40, 1'b1, 1'b1);
        cyc("postf", 1'b0, 1'b1, 32'h80, 1'b0, 1'b0);
        cyc("head",  1'b0, 1'b0, 32'h0,  1'b0, 1'b0);
        cyc("fle",   1'b0, 1'b0, 32'h0,  1'b1, 1'b0);
        cyc("fle",   1'b0, 1'b0, 32'h0,  1'b0, 1'b1);

        // reset mid-operation with a concurrent flush
        cyc("pre3r", 1'b0, 1'b1, 32'h200, 1'b0, 1'b0);
        cyc("pre3r", 1'b0, 1'b1, 32'h204, 1'b0, 1'b0);
        cyc("pre3r", 1'b0, 1'b1, 32'h208, 1'b0, 1'b0);
        cyc("rstm",  1'b1, 1'b1, 32'h20C, 1'b1, 1'b1);
        cyc("postr", 1'b0, 1'b1, 32'h300, 1'b0, 1'b0);
        cyc("postr", 1'b0, 1'b0, 32'h0,   1'b1, 1'b0);
        @(negedge clk);
        check_outputs("end");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
